// File: rtl/fixed_requantizer_pkg.sv
// Shared constants for the fixed-point requantizer: rounding mode names and
// signed range limits for a given word width.
package fixed_requantizer_pkg;

    localparam string ROUND_TRUNC   = "TRUNC";
    localparam string ROUND_HALF_UP = "HALF_UP";

    // Largest value representable in a signed word of the given width.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fixed_requantizer_pipe_reg.sv
// Generic valid/ready register slice carrying a W-bit word plus a 1-bit flag.
// Loads when empty or when its current contents leave on the same edge.
module fixed_requantizer_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_flag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_flag
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic         flag_q;
    logic         load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= in_data;
                flag_q <= in_flag;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_flag  = flag_q;

endmodule

// File: rtl/fixed_requantizer.sv
// Requantizes wide signed fixed-point sums to a narrower Q format: stage 1
// rounds, stage 2 saturates and drives the output; saturations feed status.
module fixed_requantizer
    import fixed_requantizer_pkg::*;
#(
    parameter int    IN_WIDTH  = 20,
    parameter int    IN_FRAC   = 16,
    parameter int    OUT_WIDTH = 16,
    parameter int    OUT_FRAC  = 14,
    parameter string ROUND     = "HALF_UP",
    parameter int    CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_ovf,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_sat,
    input  logic                 clr_status,
    output logic                 sat_sticky,
    output logic [CNT_WIDTH-1:0] sat_count
);

    localparam int D  = IN_FRAC - OUT_FRAC;
    localparam int RW = IN_WIDTH + 1;

    localparam logic signed [RW-1:0]  MAX_R   = RW'(sat_max(OUT_WIDTH));
    localparam logic signed [RW-1:0]  MIN_R   = RW'(sat_min(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]  OUT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]  OUT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

    if (OUT_FRAC > IN_FRAC || (OUT_WIDTH - OUT_FRAC) > (IN_WIDTH - IN_FRAC) ||
        (ROUND != ROUND_TRUNC && ROUND != ROUND_HALF_UP)) begin : g_bad_params
        $error("fixed_requantizer: illegal parameter combination");
    end

    // One guard bit keeps the half-up bias from wrapping the most positive input.
    logic signed [RW-1:0] s_ext;
    logic signed [RW-1:0] r_round;

    assign s_ext = {s_data[IN_WIDTH-1], s_data};

    if (D == 0) begin : g_no_round
        assign r_round = s_ext;
    end else if (ROUND == ROUND_TRUNC) begin : g_trunc
        assign r_round = s_ext >>> D;
    end else begin : g_half_up
        localparam logic signed [RW-1:0] HALF = RW'(1) <<< (D - 1);
        assign r_round = (s_ext + HALF) >>> D;
    end

    logic          st1_valid;
    logic          st1_ready;
    logic [RW:0]   st1_data;
    logic          st1_ovf;
    logic          st1_in_ready;

    fixed_requantizer_pipe_reg #(.W(RW + 1)) u_round_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_ready  (st1_in_ready),
        .in_data   ({s_data[IN_WIDTH-1], r_round}),
        .in_flag   (s_ovf),
        .out_valid (st1_valid),
        .out_ready (st1_ready),
        .out_data  (st1_data),
        .out_flag  (st1_ovf)
    );

    assign s_ready = st1_in_ready && !rst;

    logic signed [RW-1:0]  r1;
    logic                  wrapped_msb;
    logic [OUT_WIDTH-1:0]  sat_data;
    logic                  sat_flag;

    assign r1          = st1_data[RW-1:0];
    assign wrapped_msb = st1_data[RW];

    // A wrapped upstream sum lies on the opposite side of its apparent sign.
    always_comb begin
        sat_data = r1[OUT_WIDTH-1:0];
        sat_flag = 1'b0;
        if (st1_ovf) begin
            sat_data = wrapped_msb ? OUT_MAX : OUT_MIN;
            sat_flag = 1'b1;
        end else if (r1 > MAX_R) begin
            sat_data = OUT_MAX;
            sat_flag = 1'b1;
        end else if (r1 < MIN_R) begin
            sat_data = OUT_MIN;
            sat_flag = 1'b1;
        end
    end

    fixed_requantizer_pipe_reg #(.W(OUT_WIDTH)) u_sat_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (st1_valid),
        .in_ready  (st1_ready),
        .in_data   (sat_data),
        .in_flag   (sat_flag),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_flag  (m_sat)
    );

    logic                 sticky_q;
    logic                 sticky_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // A clear on the same edge as a saturated delivery wins; that event is not counted.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_status) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (m_valid && m_ready && m_sat) begin
            sticky_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign sat_sticky = sticky_q;
    assign sat_count  = count_q;

endmodule
